// File: rtl/merge_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : merge_scheduler_pkg
// Description : Shared definitions for the two-way merge scheduler: FSM state
//               encoding, sentinel-block builder and record-0 key extraction.
// Revision    : 1.0 - initial release
// ============================================================================
package merge_scheduler_pkg;

   // Scheduler state encoding
   localparam int STATE_W = 3;
   typedef logic [STATE_W-1:0] state_t;

   localparam state_t S_IDLE  = 3'd0;
   localparam state_t S_CLEAR = 3'd1;
   localparam state_t S_MERGE = 3'd2;
   localparam state_t S_FLUSH = 3'd3;
   localparam state_t S_DRAIN = 3'd4;

   // Upper bounds for the width-generic helpers below; callers cast the
   // results to their own block/key widths.
   localparam int MAX_BLKW = 1024;
   localparam int MAX_KEYW = 256;

   // Block whose every record carries an all-ones key and a zero payload.
   // Such a record sorts after any real record and pushes the contents of
   // the network's feedback buffers out.
   function automatic logic [MAX_BLKW-1:0] sentinel_block(input int e,
                                                          input int datw,
                                                          input int keyw);
      logic [MAX_BLKW-1:0] blk;
      logic [MAX_BLKW-1:0] rec;
      blk = '0;
      rec = ~({MAX_BLKW{1'b1}} << keyw);
      for (int r = 0; r < e; r++) begin
         blk = blk | (rec << (r * datw));
      end
      return blk;
   endfunction

   // Key of record 0 (the smallest record of a sorted block): its low keyw bits.
   function automatic logic [MAX_KEYW-1:0] rec0_key(input logic [MAX_BLKW-1:0] blk,
                                                    input int keyw);
      logic [MAX_KEYW-1:0] mask;
      mask = ~({MAX_KEYW{1'b1}} << keyw);
      return blk[MAX_KEYW-1:0] & mask;
   endfunction

endpackage : merge_scheduler_pkg
`default_nettype wire

// File: rtl/merge_scheduler_select.sv
`default_nettype none
// ============================================================================
// Module      : merge_select
// Description : Combinational stream selection for one merge cycle. Decides
//               whether a block can be taken this cycle and from which FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module merge_select
   import merge_scheduler_pkg::*;
#(
   parameter int KEYW = 32
)(
   input  logic            en_i,       // MERGE state and not stalled
   input  logic            rem0_nz_i,  // stream 0 still has blocks to send
   input  logic            rem1_nz_i,  // stream 1 still has blocks to send
   input  logic            in0_emp_i,
   input  logic            in1_emp_i,
   input  logic [KEYW-1:0] key0_i,     // record-0 key of FIFO 0 head
   input  logic [KEYW-1:0] key1_i,     // record-0 key of FIFO 1 head
   output logic            fire_o,     // a block is taken this cycle
   output logic            sel_o       // 0: FIFO 0, 1: FIFO 1
);

   // While both streams are live, both heads must be visible before a
   // decision is made; substituting the non-empty stream would break order.
   always_comb begin
      fire_o = 1'b0;
      sel_o  = 1'b0;
      if (en_i) begin
         if (rem0_nz_i && rem1_nz_i) begin
            if (!in0_emp_i && !in1_emp_i) begin
               fire_o = 1'b1;
               sel_o  = (key0_i <= key1_i) ? 1'b0 : 1'b1;   // tie goes to stream 0
            end
         end else if (rem0_nz_i) begin
            fire_o = !in0_emp_i;
         end else if (rem1_nz_i) begin
            fire_o = !in1_emp_i;
            sel_o  = 1'b1;
         end
      end
   end

endmodule : merge_select
`default_nettype wire

// File: rtl/merge_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : merge_scheduler
// Description : Sequences one two-way merge run through the E-record merge
//               network: clears the network, feeds blocks from two sorted
//               FIFOs in key order, appends a sentinel block, counts output
//               blocks and pulses DONE when all have emerged.
// Revision    : 1.0 - initial release
// ============================================================================
module merge_scheduler
   import merge_scheduler_pkg::*;
#(
   parameter int E_LOG = 2,
   parameter int DATW  = 64,
   parameter int KEYW  = 32,
   parameter int LENW  = 16
)(
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   START,
   input  logic [LENW-1:0]        LEN0,
   input  logic [LENW-1:0]        LEN1,
   input  logic [(DATW<<E_LOG)-1:0] IN0_DOT,
   input  logic                   IN0_EMP,
   output logic                   IN0_DEQ,
   input  logic [(DATW<<E_LOG)-1:0] IN1_DOT,
   input  logic                   IN1_EMP,
   output logic                   IN1_DEQ,
   input  logic                   OUT_FULL,
   output logic                   NET_RST,
   output logic                   NET_STALL,
   output logic [(DATW<<E_LOG)-1:0] NET_DIN,
   output logic                   NET_DINEN,
   input  logic                   NET_DOTEN,
   output logic                   BUSY,
   output logic                   DONE
);

   localparam int E    = 1 << E_LOG;
   localparam int BLKW = DATW << E_LOG;
   localparam logic [BLKW-1:0] SENTINEL = BLKW'(sentinel_block(E, DATW, KEYW));

   state_t          state_q, state_d;
   logic [LENW-1:0] rem0_q, rem0_d;
   logic [LENW-1:0] rem1_q, rem1_d;
   logic [LENW:0]   total_q, total_d;
   logic [LENW:0]   cnt_q, cnt_d;
   logic            zdone_q, zdone_d;

   logic [KEYW-1:0] key0_w, key1_w;
   logic            sel_en_w, fire_w, sel_w;
   logic            last_w, start_w, start_zero_w, drain_done_w, cnt_en_w;

   assign key0_w = KEYW'(rec0_key(MAX_BLKW'(IN0_DOT), KEYW));
   assign key1_w = KEYW'(rec0_key(MAX_BLKW'(IN1_DOT), KEYW));

   // A stalled cycle is a no-op everywhere except CLEAR, so START is only
   // taken when downstream has room.
   assign start_w      = (state_q == S_IDLE) && START && !OUT_FULL && !RST;
   assign start_zero_w = start_w && (LEN0 == '0) && (LEN1 == '0);
   assign sel_en_w     = (state_q == S_MERGE) && !OUT_FULL && !RST;
   assign drain_done_w = (state_q == S_DRAIN) && (cnt_q == total_q) && !OUT_FULL;
   assign cnt_en_w     = ((state_q == S_MERGE) || (state_q == S_FLUSH) ||
                          (state_q == S_DRAIN)) && NET_DOTEN && !OUT_FULL;

   // Taking this block leaves both streams exhausted
   assign last_w = sel_w ? ((rem1_q == LENW'(1)) && (rem0_q == '0))
                         : ((rem0_q == LENW'(1)) && (rem1_q == '0));

   merge_select #(
      .KEYW      (KEYW)
   ) u_select (
      .en_i      (sel_en_w),
      .rem0_nz_i (rem0_q != '0),
      .rem1_nz_i (rem1_q != '0),
      .in0_emp_i (IN0_EMP),
      .in1_emp_i (IN1_EMP),
      .key0_i    (key0_w),
      .key1_i    (key1_w),
      .fire_o    (fire_w),
      .sel_o     (sel_w)
   );

   // State register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_w && !start_zero_w) state_d = S_CLEAR;
         S_CLEAR: state_d = S_MERGE;
         S_MERGE: if (fire_w && last_w)        state_d = S_FLUSH;
         S_FLUSH: if (!OUT_FULL)               state_d = S_DRAIN;
         S_DRAIN: if (drain_done_w)            state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs; the reset term keeps handshakes quiet while a run is aborted
   always_comb begin
      NET_STALL = OUT_FULL;
      NET_RST   = RST || (state_q == S_CLEAR);
      BUSY      = !RST && (state_q != S_IDLE) && !drain_done_w;
      DONE      = !RST && (zdone_q || drain_done_w);
      IN0_DEQ   = fire_w && !sel_w;
      IN1_DEQ   = fire_w && sel_w;
      NET_DINEN = fire_w || ((state_q == S_FLUSH) && !OUT_FULL && !RST);
      NET_DIN   = (state_q == S_FLUSH) ? SENTINEL : (sel_w ? IN1_DOT : IN0_DOT);
   end

   // Run bookkeeping: remaining blocks per stream, expected and seen outputs
   always_comb begin
      rem0_d  = rem0_q;
      rem1_d  = rem1_q;
      total_d = total_q;
      cnt_d   = cnt_q;
      zdone_d = start_zero_w;
      if (start_w) begin
         rem0_d  = LEN0;
         rem1_d  = LEN1;
         total_d = {1'b0, LEN0} + {1'b0, LEN1};
         cnt_d   = '0;
      end else begin
         if (fire_w && !sel_w) rem0_d = rem0_q - 1'b1;
         if (fire_w && sel_w)  rem1_d = rem1_q - 1'b1;
         if (cnt_en_w)         cnt_d  = cnt_q + 1'b1;
      end
   end

   // Bookkeeping registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         rem0_q  <= '0;
         rem1_q  <= '0;
         total_q <= '0;
         cnt_q   <= '0;
         zdone_q <= 1'b0;
      end else begin
         rem0_q  <= rem0_d;
         rem1_q  <= rem1_d;
         total_q <= total_d;
         cnt_q   <= cnt_d;
         zdone_q <= zdone_d;
      end
   end

endmodule : merge_scheduler
`default_nettype wire

// File: tb/tb_merge_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_merge_scheduler
// Description : Self-checking bench for merge_scheduler with FIFO and merge
//               network behavioural models and a cycle-level reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_merge_scheduler;

   localparam int E_LOG = 2;
   localparam int DATW  = 64;
   localparam int KEYW  = 32;
   localparam int LENW  = 16;
   localparam int E     = 1 << E_LOG;
   localparam int BLKW  = DATW << E_LOG;
   localparam int LAT   = 2 << E_LOG;

   localparam int PH_IDLE = 0, PH_CLR = 1, PH_MRG = 2, PH_FLS = 3, PH_DRN = 4, PH_ZDN = 5;

   logic            CLK = 1'b0;
   logic            RST, START, IN0_EMP, IN1_EMP, IN0_DEQ, IN1_DEQ, OUT_FULL;
   logic            NET_RST, NET_STALL, NET_DINEN, NET_DOTEN, BUSY, DONE;
   logic [LENW-1:0] LEN0, LEN1;
   logic [BLKW-1:0] IN0_DOT, IN1_DOT, NET_DIN;

   always #5 CLK = ~CLK;

   merge_scheduler #(
      .E_LOG(E_LOG), .DATW(DATW), .KEYW(KEYW), .LENW(LENW)
   ) dut (
      .CLK(CLK), .RST(RST), .START(START), .LEN0(LEN0), .LEN1(LEN1),
      .IN0_DOT(IN0_DOT), .IN0_EMP(IN0_EMP), .IN0_DEQ(IN0_DEQ),
      .IN1_DOT(IN1_DOT), .IN1_EMP(IN1_EMP), .IN1_DEQ(IN1_DEQ),
      .OUT_FULL(OUT_FULL), .NET_RST(NET_RST), .NET_STALL(NET_STALL),
      .NET_DIN(NET_DIN), .NET_DINEN(NET_DINEN), .NET_DOTEN(NET_DOTEN),
      .BUSY(BUSY), .DONE(DONE)
   );

   int n_chk = 0, n_pass = 0, n_fail = 0;

   logic [BLKW-1:0] q0[$], q1[$];
   logic [BLKW-1:0] sentinel;
   int              sel_log[$], ref_order[$];
   bit              net_pipe[LAT];
   bit              net_first;
   bit              rst_now;
   int              ph, r0, r1, total, cnt;
   int              empty_pct, full_pct, burst_at, burst_left, run_cyc;

   task automatic chk(input string tag, input logic [BLKW-1:0] obs, input logic [BLKW-1:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Sorted stream with random keys; small steps make equal keys common
   task automatic gen_stream(input int which, input int len);
      int unsigned     k;
      logic [BLKW-1:0] b;
      k = $urandom_range(0, 3);
      for (int i = 0; i < len; i++) begin
         b = '0;
         for (int r = 0; r < E; r++) begin
            b[r*DATW +: KEYW]             = k;
            b[r*DATW+KEYW +: DATW-KEYW]   = $urandom;
            k += $urandom_range(0, 2);
         end
         if (which == 0) q0.push_back(b); else q1.push_back(b);
      end
   endtask

   task automatic put_block(input int which, input int k0, input int kstep);
      logic [BLKW-1:0] b;
      b = '0;
      for (int r = 0; r < E; r++) b[r*DATW +: KEYW] = k0 + r * kstep;
      if (which == 0) q0.push_back(b); else q1.push_back(b);
   endtask

   // One clock cycle: drive the environment, then compare every output with
   // what the scheduling rules require for this cycle.
   task automatic step(input bit st);
      bit              full, e0, e1, x0, x1, xf, xdone, xbusy, xnrst;
      logic [BLKW-1:0] xdin;
      @(negedge CLK);
      if (burst_left > 0) begin
         full = 1'b1; burst_left--;
      end else if (run_cyc == burst_at) begin
         full = 1'b1; burst_left = 9;
      end else begin
         full = ($urandom_range(0, 99) < full_pct);
      end
      if (st) full = 1'b0;
      e0 = (q0.size() == 0) || ($urandom_range(0, 99) < empty_pct);
      e1 = (q1.size() == 0) || ($urandom_range(0, 99) < empty_pct);
      RST       = rst_now;
      START     = st;
      OUT_FULL  = full;
      IN0_EMP   = e0;
      IN1_EMP   = e1;
      IN0_DOT   = (q0.size() != 0) ? q0[0] : {8{$urandom}};
      IN1_DOT   = (q1.size() != 0) ? q1[0] : {8{$urandom}};
      NET_DOTEN = net_pipe[LAT-1];
      #1;
      x0 = 0; x1 = 0; xf = 0; xdone = 0;
      xbusy = (ph != PH_IDLE) && (ph != PH_ZDN);
      xnrst = (ph == PH_CLR);
      case (ph)
         PH_MRG: if (!full) begin
            if (r0 > 0 && r1 > 0) begin
               if (!e0 && !e1) begin
                  if (q0[0][KEYW-1:0] <= q1[0][KEYW-1:0]) x0 = 1; else x1 = 1;
               end
            end else if (r0 > 0) x0 = !e0;
            else if (r1 > 0) x1 = !e1;
         end
         PH_FLS: xf = !full;
         PH_DRN: if (!full && cnt == total) begin xdone = 1; xbusy = 0; end
         PH_ZDN: xdone = 1;
         default: ;
      endcase
      if (rst_now) begin
         x0 = 0; x1 = 0; xf = 0; xdone = 0; xbusy = 0; xnrst = 1;
      end
      chk("stall",   NET_STALL, full);
      chk("deq0",    IN0_DEQ,   x0);
      chk("deq1",    IN1_DEQ,   x1);
      chk("dinen",   NET_DINEN, x0 | x1 | xf);
      chk("net_rst", NET_RST,   xnrst);
      chk("busy",    BUSY,      xbusy);
      chk("done",    DONE,      xdone);
      if (x0 | x1 | xf) begin
         xdin = xf ? sentinel : (x1 ? q1[0] : q0[0]);
         chk("din", NET_DIN, xdin);
      end
      if (IN0_DEQ === 1'b1) sel_log.push_back(0);
      if (IN1_DEQ === 1'b1) sel_log.push_back(1);
      // merge network environment: fixed latency, first ejection suppressed
      if (NET_RST === 1'b1) begin
         for (int i = 0; i < LAT; i++) net_pipe[i] = 0;
         net_first = 1;
      end else if (!full) begin
         for (int i = LAT - 1; i > 0; i--) net_pipe[i] = net_pipe[i-1];
         net_pipe[0] = (NET_DINEN === 1'b1) && !net_first;
         if (NET_DINEN === 1'b1) net_first = 0;
      end
      if (NET_DOTEN && !full && (ph == PH_MRG || ph == PH_FLS || ph == PH_DRN)) cnt++;
      if (x0) begin void'(q0.pop_front()); r0--; end
      if (x1) begin void'(q1.pop_front()); r1--; end
      case (ph)
         PH_IDLE: if (st) begin
            r0 = int'(LEN0); r1 = int'(LEN1); total = r0 + r1; cnt = 0;
            ph = (total == 0) ? PH_ZDN : PH_CLR;
         end
         PH_ZDN: ph = PH_IDLE;
         PH_CLR: ph = PH_MRG;
         PH_MRG: if ((x0 | x1) && r0 == 0 && r1 == 0) ph = PH_FLS;
         PH_FLS: if (xf) ph = PH_DRN;
         PH_DRN: if (xdone) ph = PH_IDLE;
         default: ;
      endcase
      if (rst_now) ph = PH_IDLE;
      run_cyc++;
   endtask

   // mode 0: random sorted data, 1: interleaved 1..8E keys, 2: equal head keys
   task automatic run(input int l0, input int l1, input int mode, input bit abort_drain);
      int i, j, guard;
      int k0s[$], k1s[$];
      q0.delete(); q1.delete(); sel_log.delete(); ref_order.delete();
      if (mode == 0) begin
         gen_stream(0, l0); gen_stream(1, l1);
      end else begin
         for (int b = 0; b < l0; b++) put_block(0, (mode == 1) ? 8*b + 1 : 5 + 4*b, (mode == 1) ? 2 : 1);
         for (int b = 0; b < l1; b++) put_block(1, (mode == 1) ? 8*b + 2 : 5 + 4*b, (mode == 1) ? 2 : 1);
      end
      foreach (q0[n]) k0s.push_back(int'(q0[n][KEYW-1:0]));
      foreach (q1[n]) k1s.push_back(int'(q1[n][KEYW-1:0]));
      i = 0; j = 0;
      while (i < l0 || j < l1) begin
         if (j >= l1 || (i < l0 && k0s[i] <= k1s[j])) begin ref_order.push_back(0); i++; end
         else begin ref_order.push_back(1); j++; end
      end
      LEN0 = LENW'(l0); LEN1 = LENW'(l1);
      run_cyc = 0;
      step(1);
      guard = 0;
      while (ph != PH_IDLE && guard < 3000) begin
         if (abort_drain && ph == PH_DRN) begin
            rst_now = 1; step(0); step(0); rst_now = 0;
            break;
         end
         step(0);
         guard++;
      end
      chk("run_end_phase", ph, PH_IDLE);
      if (!abort_drain) begin
         chk("order_len", sel_log.size(), ref_order.size());
         foreach (ref_order[n]) if (n < sel_log.size()) chk("order", sel_log[n], ref_order[n]);
      end
      step(0);
      step(0);
      burst_at = -1;
   endtask

   initial begin
      sentinel = '0;
      for (int r = 0; r < E; r++) sentinel[r*DATW +: KEYW] = '1;
      for (int i = 0; i < LAT; i++) net_pipe[i] = 0;
      net_first = 1;
      ph = PH_IDLE; r0 = 0; r1 = 0; total = 0; cnt = 0;
      empty_pct = 0; full_pct = 0; burst_at = -1; burst_left = 0; run_cyc = 0;
      START = 0; LEN0 = '0; LEN1 = '0;
      // reset state
      rst_now = 1;
      step(0); step(0);
      rst_now = 0;
      step(0);
      // interleaved streams, no back-pressure
      run(2, 2, 1, 0);
      // single stream only
      run(3, 0, 0, 0);
      // zero-length run
      run(0, 0, 0, 0);
      // equal head keys with frequent empties
      empty_pct = 40;
      run(1, 1, 2, 0);
      run(2, 2, 2, 0);
      empty_pct = 0;
      // ten-cycle stall mid-merge
      burst_at = 4;
      run(2, 2, 1, 0);
      // abort in drain, then a clean rerun
      run(2, 2, 1, 1);
      run(2, 2, 1, 0);
      // randomized runs with back-pressure and empties
      full_pct = 20; empty_pct = 25;
      for (int t = 0; t < 8; t++) run($urandom_range(0, 6), $urandom_range(0, 6), 0, 0);
      run(0, 5, 0, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_merge_scheduler
`default_nettype wire
